// File: rtl/energy_smoother_pkg.sv
// Shared constants and helpers for the clap-detector energy path.
package energy_smoother_pkg;

    // Audio sample width and energy integration length used across the chain.
    localparam int unsigned CLAP_SAMPLE_WIDTH = 16;
    localparam int unsigned CLAP_DURATION     = 8;

    // Ceiling log2; clogb2(1) is 0.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            v = v >> 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Energy is a sum of squared samples over CLAP_DURATION frames.
    localparam int unsigned CLAP_ENERGY_WIDTH =
        CLAP_SAMPLE_WIDTH * 2 + clogb2(CLAP_DURATION);

endpackage

// File: rtl/energy_window_ram.sv
// Simple dual-port RAM holding the averaging window: one write port,
// one synchronous read port.
module energy_window_ram #(
    parameter int unsigned ENERGY_WIDTH = 35,
    parameter int unsigned ADDR_WIDTH   = 3
) (
    input  logic                    clock,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [ENERGY_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [ENERGY_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [ENERGY_WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port.
    always_ff @(posedge clock) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/energy_smoother.sv
// Moving-average filter: emits the mean of the last 2^WINDOW_LOG2 accepted
// energy words, with a zero-filled window at startup.
module energy_smoother
    import energy_smoother_pkg::*;
#(
    parameter int unsigned ENERGY_WIDTH = CLAP_ENERGY_WIDTH,
    parameter int unsigned WINDOW_LOG2  = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ENERGY_WIDTH-1:0] energy_in_data,
    input  logic                    energy_in_valid,
    output logic                    energy_in_ready,
    output logic [ENERGY_WIDTH-1:0] energy_out_data,
    output logic                    energy_out_valid,
    input  logic                    energy_out_ready
);

    localparam int unsigned WINDOW     = 1 << WINDOW_LOG2;
    localparam int unsigned FILL_WIDTH = WINDOW_LOG2 + 1;
    localparam int unsigned ACC_WIDTH  = ENERGY_WIDTH + WINDOW_LOG2;

    logic [WINDOW_LOG2-1:0]  wr_ptr;
    logic [WINDOW_LOG2-1:0]  wr_ptr_next;
    logic [FILL_WIDTH-1:0]   fill;
    logic [ACC_WIDTH-1:0]    acc;
    logic [ACC_WIDTH-1:0]    acc_next;
    logic [ENERGY_WIDTH-1:0] rd_data;
    logic [ENERGY_WIDTH-1:0] old_word;
    logic                    window_full;
    logic                    accept;

    assign energy_in_ready = !energy_out_valid || energy_out_ready;
    assign accept          = energy_in_valid && energy_in_ready;
    assign window_full     = (fill == FILL_WIDTH'(WINDOW));

    // Next write pointer; it also addresses the RAM read so that the word
    // about to be overwritten is already on rd_data in the next accept cycle.
    always_comb begin
        wr_ptr_next = wr_ptr;
        if (reset) begin
            wr_ptr_next = '0;
        end else if (accept) begin
            wr_ptr_next = wr_ptr + WINDOW_LOG2'(1);
        end
    end

    // Running window sum; the evicted word only counts once the window is full.
    always_comb begin
        old_word = window_full ? rd_data : '0;
        acc_next = acc + ACC_WIDTH'(energy_in_data) - ACC_WIDTH'(old_word);
    end

    energy_window_ram #(
        .ENERGY_WIDTH (ENERGY_WIDTH),
        .ADDR_WIDTH   (WINDOW_LOG2)
    ) u_window_ram (
        .clock   (clock),
        .wr_en   (accept && !reset),
        .wr_addr (wr_ptr),
        .wr_data (energy_in_data),
        .rd_addr (wr_ptr_next),
        .rd_data (rd_data)
    );

    // Window state: pointer, fill level and accumulator.
    always_ff @(posedge clock) begin
        wr_ptr <= wr_ptr_next;
        if (reset) begin
            fill <= '0;
            acc  <= '0;
        end else if (accept) begin
            acc <= acc_next;
            if (!window_full) begin
                fill <= fill + FILL_WIDTH'(1);
            end
        end
    end

    // Single output register with pass-through backpressure.
    always_ff @(posedge clock) begin
        if (reset) begin
            energy_out_valid <= 1'b0;
            energy_out_data  <= '0;
        end else if (accept) begin
            energy_out_valid <= 1'b1;
            energy_out_data  <= acc_next[ACC_WIDTH-1:WINDOW_LOG2];
        end else if (energy_out_ready) begin
            energy_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_energy_smoother.sv
// Self-checking bench for energy_smoother with a sliding-window mean model.
module tb_energy_smoother;

    localparam int unsigned EW  = 35;
    localparam int unsigned WL  = 3;
    localparam int unsigned WIN = 1 << WL;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [EW-1:0] energy_in_data = '0;
    logic          energy_in_valid = 1'b0;
    logic          energy_in_ready;
    logic [EW-1:0] energy_out_data;
    logic          energy_out_valid;
    logic          energy_out_ready = 1'b1;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [EW-1:0]     max_word;
    longint unsigned   win_q[$];
    logic [EW-1:0]     exp_q[$];
    logic [EW-1:0]     got_q[$];

    energy_smoother #(
        .ENERGY_WIDTH (EW),
        .WINDOW_LOG2  (WL)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .energy_in_data   (energy_in_data),
        .energy_in_valid  (energy_in_valid),
        .energy_in_ready  (energy_in_ready),
        .energy_out_data  (energy_out_data),
        .energy_out_valid (energy_out_valid),
        .energy_out_ready (energy_out_ready)
    );

    always #5 clock = ~clock;

    // Reference: mean of the last WIN accepted words, missing words count as 0.
    task automatic model_accept(input logic [EW-1:0] d);
        longint unsigned sum;
        win_q.push_back(longint'(d));
        if (win_q.size() > WIN) void'(win_q.pop_front());
        sum = 0;
        foreach (win_q[i]) sum += win_q[i];
        exp_q.push_back(EW'(sum / WIN));
    endtask

    // One clock: record handshakes seen this cycle, then advance.
    task automatic step(output bit accepted);
        bit a;
        bit e;
        #2;
        a = energy_in_valid && energy_in_ready;
        e = energy_out_valid && energy_out_ready;
        if (e) got_q.push_back(energy_out_data);
        if (a) model_accept(energy_in_data);
        accepted = a;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        energy_in_valid = 1'b0;
        energy_out_ready = 1'b1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        win_q.delete();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic drain();
        bit a;
        energy_in_valid = 1'b0;
        energy_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step(a);
    endtask

    task automatic feed_const(input logic [EW-1:0] d, input int unsigned n);
        bit a;
        int unsigned done;
        done = 0;
        energy_out_ready = 1'b1;
        for (int c = 0; c < 200 && done < n; c++) begin
            energy_in_valid = 1'b1;
            energy_in_data = d;
            step(a);
            if (a) done++;
        end
        energy_in_valid = 1'b0;
        vectors++;
        if (done !== n) begin
            miscompares++;
            $display("FAIL feed_count got %0d want %0d", done, n);
        end
    endtask

    task automatic test_reset();
        energy_in_valid = 1'b1;
        energy_in_data = 35'd12345;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        energy_in_valid = 1'b0;
        win_q.delete(); exp_q.delete(); got_q.delete();
        vectors++;
        if (energy_out_valid !== 1'b0 || energy_out_data !== '0 || energy_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state got v=%b d=%0d r=%b want v=0 d=0 r=1",
                     energy_out_valid, energy_out_data, energy_in_ready);
        end
    endtask

    task automatic test_ramp();
        logic [EW-1:0] want;
        do_reset();
        feed_const(35'd800, 8);
        feed_const(35'd0, 8);
        drain();
        vectors++;
        if (got_q.size() != 16) begin
            miscompares++;
            $display("FAIL ramp_count got %0d want 16", got_q.size());
        end
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            want = (i < 8) ? EW'((i + 1) * 100) : EW'((15 - i) * 100);
            vectors++;
            if (got_q[i] !== want) begin
                miscompares++;
                $display("FAIL ramp[%0d] got %0d want %0d", i, got_q[i], want);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [EW-1:0] words [3];
        logic [EW-1:0] want [3];
        int unsigned idx;
        bit a;
        words[0] = 35'd800;  words[1] = 35'd1600; words[2] = 35'd2400;
        want[0]  = 35'd100;  want[1]  = 35'd300;  want[2]  = 35'd600;
        do_reset();
        idx = 0;
        energy_out_ready = 1'b0;
        energy_in_valid = 1'b1;
        energy_in_data = words[0];
        step(a);
        if (a) idx = 1;
        for (int c = 0; c < 4; c++) begin
            energy_in_data = words[idx];
            step(a);
            if (a) idx++;
            vectors++;
            if (a || energy_in_ready !== 1'b0 || energy_out_valid !== 1'b1 ||
                energy_out_data !== 35'd100) begin
                miscompares++;
                $display("FAIL bp_hold[%0d] got acc=%b r=%b v=%b d=%0d want acc=0 r=0 v=1 d=100",
                         c, a, energy_in_ready, energy_out_valid, energy_out_data);
            end
        end
        energy_out_ready = 1'b1;
        for (int c = 0; c < 10 && idx < 3; c++) begin
            energy_in_data = words[idx];
            step(a);
            if (a) idx++;
        end
        drain();
        vectors++;
        if (got_q.size() != 3) begin
            miscompares++;
            $display("FAIL bp_count got %0d want 3", got_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== want[i]) begin
                miscompares++;
                $display("FAIL bp_out[%0d] got %0d want %0d", i, got_q[i], want[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit a;
        int unsigned drops;
        do_reset();
        drops = 0;
        energy_out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            energy_in_valid = 1'b1;
            energy_in_data = (i % 2 == 0) ? 35'd0 : 35'd1600;
            step(a);
            if (!a || energy_out_valid !== 1'b1) drops++;
        end
        drain();
        vectors++;
        if (drops != 0 || got_q.size() != 24) begin
            miscompares++;
            $display("FAIL stream_rate got drops=%0d outs=%0d want drops=0 outs=24", drops, got_q.size());
        end
        for (int i = 7; i < 24 && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== 35'd800) begin
                miscompares++;
                $display("FAIL stream[%0d] got %0d want 800", i, got_q[i]);
            end
        end
    endtask

    task automatic test_extremes();
        do_reset();
        feed_const(max_word, 8);
        drain();
        vectors++;
        if (got_q.size() != 8 || got_q[got_q.size()-1] !== max_word) begin
            miscompares++;
            $display("FAIL extreme_max got %0d want %0d",
                     (got_q.size() > 0) ? got_q[got_q.size()-1] : '0, max_word);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL extreme_up[%0d] got %0d want %0d", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
        feed_const(35'd0, 8);
        drain();
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL extreme_down[%0d] got %0d want %0d", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (got_q.size() != 8 || got_q[got_q.size()-1] !== '0) begin
            miscompares++;
            $display("FAIL extreme_zero got count %0d want last 0 of 8", got_q.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        feed_const(35'd800, 5);
        energy_in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        win_q.delete(); exp_q.delete(); got_q.delete();
        vectors++;
        if (energy_out_valid !== 1'b0 || energy_out_data !== '0) begin
            miscompares++;
            $display("FAIL midreset_state got v=%b d=%0d want v=0 d=0", energy_out_valid, energy_out_data);
        end
        feed_const(35'd800, 1);
        drain();
        vectors++;
        if (got_q.size() != 1 || got_q[0] !== 35'd100) begin
            miscompares++;
            $display("FAIL midreset_first got %0d (count %0d) want 100",
                     (got_q.size() > 0) ? got_q[0] : '0, got_q.size());
        end
    endtask

    task automatic test_random();
        bit a;
        int unsigned accepted;
        bit prev_v, prev_r;
        logic [EW-1:0] prev_d;
        logic [63:0] r;
        do_reset();
        accepted = 0;
        for (int c = 0; c < 60000 && accepted < 10000; c++) begin
            r = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: energy_in_data = max_word;
                1: energy_in_data = '0;
                default: energy_in_data = r[EW-1:0];
            endcase
            energy_in_valid = ($urandom_range(0, 3) != 0);
            energy_out_ready = ($urandom_range(0, 3) != 0);
            prev_v = energy_out_valid;
            prev_r = energy_out_ready;
            prev_d = energy_out_data;
            step(a);
            if (a) accepted++;
            if (prev_v && !prev_r) begin
                vectors++;
                if (energy_out_valid !== 1'b1 || energy_out_data !== prev_d) begin
                    miscompares++;
                    $display("FAIL rand_hold got v=%b d=%0d want v=1 d=%0d",
                             energy_out_valid, energy_out_data, prev_d);
                end
            end
        end
        drain();
        vectors++;
        if (accepted != 10000 || got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL rand_count got acc=%0d outs=%0d want acc=10000 outs=%0d",
                     accepted, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL rand[%0d] got %0d want %0d", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        max_word = '1;
        @(posedge clock);
        #1;
        test_reset();
        test_ramp();
        test_backpressure();
        test_back_to_back();
        test_extremes();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
